// File: rtl/lolap_sponge_ctrl.sv
// Sponge controller in front of the combinational LolaP permutation.
// Absorbs 32-bit message words into the rate, pads with domain separation,
// runs LolaP through a multicycle settle window and squeezes the digest out.
module lolap_sponge_ctrl #(
  parameter int WORD_W     = 32,
  parameter int RATE_WORDS = 4,
  parameter int PERM_WAIT  = 1,
  parameter int OUT_WORDS  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] msg_data_i,
  input  logic              msg_valid_i,
  input  logic              msg_last_i,
  output logic              msg_ready_o,
  output logic [256:0]      perm_o,
  input  logic [256:0]      perm_i,
  output logic [WORD_W-1:0] dig_data_o,
  output logic              dig_valid_o,
  input  logic              dig_ready_i,
  output logic              busy_o
);

  localparam int RATE_W = WORD_W * RATE_WORDS;
  localparam int KW     = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int CW     = $clog2(PERM_WAIT + 1);

  localparam logic [KW-1:0] K_RATE_LAST = KW'(RATE_WORDS - 1);
  localparam logic [KW-1:0] K_OUT_LAST  = KW'(OUT_WORDS - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(PERM_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ABSORB  = 3'd1,
    PERM    = 3'd2,
    PAD     = 3'd3,
    SQUEEZE = 3'd4
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  fsm_e              ret_q, ret_d;
  logic [256:0]      s_q, s_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              msg_ready_q, msg_ready_d;
  logic              dig_valid_q, dig_valid_d;
  logic [WORD_W-1:0] dig_data_q, dig_data_d;
  logic              busy_q, busy_d;

  // Next-state, sponge state update and registered-output decode.
  always_comb begin
    fsm_d = fsm_q;
    ret_d = ret_q;
    s_d   = s_q;
    k_d   = k_q;
    cnt_d = cnt_q;

    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          s_d   = '0;
          k_d   = '0;
          fsm_d = ABSORB;
        end
      end

      ABSORB: begin
        if (msg_valid_i && msg_ready_q) begin
          for (int i = 0; i < RATE_WORDS; i++) begin
            if (int'(k_q) == i) s_d[WORD_W*i +: WORD_W] = s_d[WORD_W*i +: WORD_W] ^ msg_data_i;
          end
          if (!msg_last_i) begin
            if (k_q == K_RATE_LAST) begin
              k_d   = '0;
              fsm_d = PERM;
              ret_d = ABSORB;
            end else begin
              k_d = k_q + KW'(1);
            end
          end else if (k_q != K_RATE_LAST) begin
            // Partial block: pad bit right after the last word, plus domain bit.
            for (int i = 0; i < RATE_WORDS; i++) begin
              if (int'(k_q) + 1 == i) s_d[WORD_W*i] = ~s_d[WORD_W*i];
            end
            s_d[RATE_W] = ~s_d[RATE_W];
            k_d   = '0;
            fsm_d = PERM;
            ret_d = SQUEEZE;
          end else begin
            // Full final block: padding goes into an extra block after PERM.
            k_d   = '0;
            fsm_d = PERM;
            ret_d = PAD;
          end
        end
      end

      PERM: begin
        if (cnt_q == CNT_LAST) begin
          s_d   = perm_i;
          cnt_d = '0;
          fsm_d = ret_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PAD: begin
        s_d[0]      = ~s_d[0];
        s_d[RATE_W] = ~s_d[RATE_W];
        fsm_d       = PERM;
        ret_d       = SQUEEZE;
      end

      SQUEEZE: begin
        if (dig_valid_q && dig_ready_i) begin
          if (k_q == K_OUT_LAST) begin
            k_d   = '0;
            fsm_d = IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      default: fsm_d = IDLE;
    endcase

    msg_ready_d = (fsm_d == ABSORB);
    dig_valid_d = (fsm_d == SQUEEZE);
    busy_d      = (fsm_d != IDLE);
    dig_data_d  = '0;
    if (fsm_d == SQUEEZE) begin
      for (int i = 0; i < RATE_WORDS; i++) begin
        if (int'(k_d) == i) dig_data_d = s_d[WORD_W*i +: WORD_W];
      end
    end
  end

  // All state and outputs registered; reset discards any message in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q       <= IDLE;
      ret_q       <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      msg_ready_q <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      ret_q       <= ret_d;
      s_q         <= s_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      msg_ready_q <= msg_ready_d;
      dig_valid_q <= dig_valid_d;
      dig_data_q  <= dig_data_d;
      busy_q      <= busy_d;
    end
  end

  assign perm_o      = s_q;
  assign msg_ready_o = msg_ready_q;
  assign dig_valid_o = dig_valid_q;
  assign dig_data_o  = dig_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_lolap_sponge_ctrl.sv
// Directed bench for lolap_sponge_ctrl with LolaP stood in by bitwise NOT.
module tb_lolap_sponge_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [31:0]  msg_data_i;
  logic         msg_valid_i;
  logic         msg_last_i;
  logic         msg_ready_o;
  logic [256:0] perm_o;
  logic [256:0] perm_i;
  logic [31:0]  dig_data_o;
  logic         dig_valid_o;
  logic         dig_ready_i;
  logic         busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [256:0] B0   = 257'd1;
  localparam logic [256:0] B32  = 257'd1 << 32;
  localparam logic [256:0] B128 = 257'd1 << 128;

  localparam logic [127:0] DIG2 = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
  localparam logic [127:0] DIG3 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111110};
  localparam logic [256:0] S3   = {129'd0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  always #5 clk_i = ~clk_i;

  assign perm_i = ~perm_o;

  lolap_sponge_ctrl #(
    .WORD_W(32), .RATE_WORDS(4), .PERM_WAIT(1), .OUT_WORDS(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_last_i(msg_last_i),
    .msg_ready_o(msg_ready_o), .perm_o(perm_o), .perm_i(perm_i),
    .dig_data_o(dig_data_o), .dig_valid_o(dig_valid_o), .dig_ready_i(dig_ready_i),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  busy_o,      1'b0);
    chk({tag, "_ready"}, msg_ready_o, 1'b0);
    chk({tag, "_dvld"},  dig_valid_o, 1'b0);
    chk({tag, "_ddat"},  dig_data_o,  32'h0);
    chk({tag, "_perm"},  perm_o,      257'h0);
  endtask

  task automatic start_msg();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_ready", msg_ready_o, 1'b1);
    chk("start_busy",  busy_o,      1'b1);
  endtask

  task automatic send_word(input logic [31:0] data, input logic last, input int gap);
    int t;
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    msg_data_i  = data;
    msg_valid_i = 1'b1;
    msg_last_i  = last;
    t = 0;
    while (!msg_ready_o && t < 20) begin
      tick();
      t++;
    end
    chk("send_timeout", 257'(t >= 20), 257'd0);
    tick();
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
  endtask

  task automatic get_digest(input logic [127:0] exp, input int stall);
    int t;
    for (int w = 0; w < 4; w++) begin
      t = 0;
      while (!dig_valid_o && t < 20) begin
        tick();
        t++;
      end
      chk("dig_timeout", 257'(t >= 20), 257'd0);
      dig_ready_i = 1'b0;
      for (int s = 0; s < stall; s++) begin
        chk("dig_stall_data",  dig_data_o,  exp[32*w +: 32]);
        chk("dig_stall_valid", dig_valid_o, 1'b1);
        tick();
      end
      dig_ready_i = 1'b1;
      chk("dig_data", dig_data_o, exp[32*w +: 32]);
      tick();
      dig_ready_i = 1'b0;
    end
    chk("dig_end_busy",  busy_o,      1'b0);
    chk("dig_end_valid", dig_valid_o, 1'b0);
  endtask

  task automatic scen2(input int gap, input int stall);
    start_msg();
    send_word(32'h00000001, 1'b1, gap);
    chk("s2_perm_in", perm_o,      B0 | B32 | B128);
    chk("s2_rdy_in_perm", msg_ready_o, 1'b0);
    chk("s2_busy_in_perm", busy_o,  1'b1);
    get_digest(DIG2, stall);
  endtask

  task automatic scen3_absorb();
    start_msg();
    msg_last_i = 1'b1;
    msg_valid_i = 1'b0;
    tick();
    chk("s3_last_novalid_rdy", msg_ready_o, 1'b1);
    chk("s3_last_novalid_perm", perm_o, 257'h0);
    msg_last_i = 1'b0;
    send_word(32'h11111111, 1'b0, 0);
    send_word(32'h22222222, 1'b0, 0);
    send_word(32'h33333333, 1'b0, 0);
    chk("s3_partial", perm_o, S3 & ~({129'd0, 32'hFFFFFFFF, 96'd0}));
    send_word(32'h44444444, 1'b1, 0);
    chk("s3_perm1_state", perm_o, S3);
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    msg_data_i  = 32'h0;
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
    dig_ready_i = 1'b0;
    #1;
    chk_idle("rst_async");
    tick();
    tick();
    rst_i = 1'b0;

    // 1: idle for three cycles, stray message traffic ignored
    msg_valid_i = 1'b1;
    msg_data_i  = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle");
    end
    msg_valid_i = 1'b0;

    // 2: single-word message
    scen2(0, 0);

    // 3: full block, PERM -> PAD -> PERM
    scen3_absorb();
    tick();
    chk("s3_pad_state", perm_o, ~S3);
    chk("s3_pad_dvld",  dig_valid_o, 1'b0);
    tick();
    chk("s3_perm2_state", perm_o, ~S3 ^ B0 ^ B128);
    chk("s3_perm2_dvld",  dig_valid_o, 1'b0);
    tick();
    chk("s3_squeeze_state", perm_o, S3 ^ B0 ^ B128);
    get_digest(DIG3, 0);

    // 4: gapped input and stalled output
    start_msg();
    msg_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_gap_rdy", msg_ready_o, 1'b1);
      chk("s4_gap_perm", perm_o, 257'h0);
    end
    send_word(32'h00000001, 1'b1, 0);
    chk("s4_perm_in", perm_o, B0 | B32 | B128);
    get_digest(DIG2, 5);

    // 5: reset while in PERM of scenario 3
    scen3_absorb();
    #1;
    rst_i = 1'b1;
    #1;
    chk_idle("rst_mid");
    tick();
    rst_i = 1'b0;
    msg_valid_i = 1'b1;
    msg_data_i  = 32'h12345678;
    tick();
    chk_idle("post_rst");
    msg_valid_i = 1'b0;
    scen2(0, 0);

    // 6: start pulses while busy are ignored
    start_msg();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("s6_absorb_rdy", msg_ready_o, 1'b1);
    send_word(32'h00000001, 1'b1, 0);
    chk("s6_perm_in", perm_o, B0 | B32 | B128);
    tick();
    start_i = 1'b1;
    get_digest(DIG2, 1);
    start_i = 1'b0;
    tick();
    chk_idle_partial: begin
      chk("s6_after_busy",  busy_o,      1'b0);
      chk("s6_after_ready", msg_ready_o, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
